// File: rtl/time_set_seq.sv
// time_set_seq: walks the clock's set-button lines until the count feedback matches a target time.
// Define TSEQ_DAY_SET_EN to build the day-programming phase; without it Dayadv stays low.
module time_set_seq #(
  parameter int MAX_RETRY = 2,
  parameter int SETTLE    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       alarm_mode,
  input  logic [6:0] tgt_min,
  input  logic [6:0] tgt_hrs,
  input  logic [6:0] tgt_day,
  input  logic [6:0] cur_min,
  input  logic [6:0] cur_hrs,
  input  logic [6:0] cur_day,
  output logic       Timeset,
  output logic       Alarmset,
  output logic       Minadv,
  output logic       Hrsadv,
  output logic       Dayadv,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CHECK  = 4'd1,
    ST_ENTER  = 4'd2,
    ST_LOAD_M = 4'd3,
    ST_ADV_M  = 4'd4,
    ST_GAP_M  = 4'd5,
    ST_LOAD_H = 4'd6,
    ST_ADV_H  = 4'd7,
    ST_GAP_H  = 4'd8,
    ST_LOAD_D = 4'd9,
    ST_ADV_D  = 4'd10,
    ST_GAP_D  = 4'd11,
    ST_VERIFY = 4'd12,
    ST_EXIT   = 4'd13,
    ST_DONE   = 4'd14
  } state_t;

  localparam logic [7:0] MAX_RETRY_C = 8'(MAX_RETRY);
  localparam logic [7:0] SETTLE_C    = 8'(SETTLE);

  state_t     state_r, state_nxt_s, after_h_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic [7:0] retry_r, retry_nxt_s;
  logic       err_nxt_s;
  logic [6:0] tmin_r, thrs_r;
  logic       mode_r;
  logic [7:0] dm_s, dh_s;
  logic       range_ok_s, match_s;
  logic       mode_on_s, ts_nxt_s, as_nxt_s, ma_nxt_s, ha_nxt_s, da_nxt_s;
  logic       busy_nxt_s, done_nxt_s;

  // Forward distance from cur to tgt on a modulo-modv dial, in 8-bit arithmetic.
  function automatic logic [7:0] mod_delta(input logic [6:0] tgt, input logic [6:0] cur,
                                           input logic [7:0] modv);
    logic [7:0] d;
    d = {1'b0, tgt} + modv - {1'b0, cur};
    return (d >= modv) ? (d - modv) : d;
  endfunction

  assign dm_s = mod_delta(tmin_r, cur_min, 8'd60);
  assign dh_s = mod_delta(thrs_r, cur_hrs, 8'd24);

`ifdef TSEQ_DAY_SET_EN
  logic [6:0] tday_r;
  logic [7:0] dd_s;
  assign dd_s       = mod_delta(tday_r, cur_day, 8'd7);
  assign after_h_s  = mode_r ? ST_VERIFY : ST_LOAD_D;
  assign range_ok_s = (tmin_r < 7'd60) && (thrs_r < 7'd24) && (mode_r || (tday_r < 7'd7));
  assign match_s    = (cur_min == tmin_r) && (cur_hrs == thrs_r) && (mode_r || (cur_day == tday_r));

  // Day target capture; only meaningful in time mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tday_r <= 7'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      tday_r <= tgt_day;
    end
  end
`else
  logic day_unused_s;
  assign day_unused_s = ^{tgt_day, cur_day};
  assign after_h_s    = ST_VERIFY;
  assign range_ok_s   = (tmin_r < 7'd60) && (thrs_r < 7'd24);
  assign match_s      = (cur_min == tmin_r) && (cur_hrs == thrs_r);
`endif

  // Target and mode capture on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmin_r <= 7'd0;
      thrs_r <= 7'd0;
      mode_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      tmin_r <= tgt_min;
      thrs_r <= tgt_hrs;
      mode_r <= alarm_mode;
    end
  end

  // State register with the shared down-counter and retry count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      retry_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      retry_r <= retry_nxt_s;
    end
  end

  // Next-state logic; cnt_r counts settle cycles in ENTER and advance cycles in ADV_x.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    retry_nxt_s = retry_r;
    err_nxt_s   = err;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_CHECK;
          retry_nxt_s = 8'd0;
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (range_ok_s) begin
          state_nxt_s = ST_ENTER;
          cnt_nxt_s   = SETTLE_C;
        end else begin
          state_nxt_s = ST_DONE;
          err_nxt_s   = 1'b1;
        end
      end
      ST_ENTER: begin
        if (cnt_r <= 8'd1) begin
          state_nxt_s = ST_LOAD_M;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      ST_LOAD_M: begin
        if (dm_s == 8'd0) begin
          state_nxt_s = ST_LOAD_H;
        end else begin
          cnt_nxt_s   = dm_s;
          state_nxt_s = ST_ADV_M;
        end
      end
      ST_ADV_M: begin
        if (cnt_r <= 8'd1) begin
          state_nxt_s = ST_GAP_M;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      ST_GAP_M: state_nxt_s = ST_LOAD_H;
      ST_LOAD_H: begin
        if (dh_s == 8'd0) begin
          state_nxt_s = after_h_s;
        end else begin
          cnt_nxt_s   = dh_s;
          state_nxt_s = ST_ADV_H;
        end
      end
      ST_ADV_H: begin
        if (cnt_r <= 8'd1) begin
          state_nxt_s = ST_GAP_H;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      ST_GAP_H: state_nxt_s = after_h_s;
`ifdef TSEQ_DAY_SET_EN
      ST_LOAD_D: begin
        if (dd_s == 8'd0) begin
          state_nxt_s = ST_VERIFY;
        end else begin
          cnt_nxt_s   = dd_s;
          state_nxt_s = ST_ADV_D;
        end
      end
      ST_ADV_D: begin
        if (cnt_r <= 8'd1) begin
          state_nxt_s = ST_GAP_D;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      ST_GAP_D: state_nxt_s = ST_VERIFY;
`endif
      ST_VERIFY: begin
        if (match_s) begin
          state_nxt_s = ST_EXIT;
        end else if (retry_r < MAX_RETRY_C) begin
          // A fresh pass re-reads the feedback, absorbing carries the clock added meanwhile.
          retry_nxt_s = retry_r + 8'd1;
          state_nxt_s = ST_LOAD_M;
        end else begin
          err_nxt_s   = 1'b1;
          state_nxt_s = ST_EXIT;
        end
      end
      ST_EXIT: state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered lines line up with the state.
  always_comb begin
    mode_on_s = 1'b0;
    ma_nxt_s  = 1'b0;
    ha_nxt_s  = 1'b0;
    da_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_ENTER, ST_LOAD_M, ST_GAP_M, ST_LOAD_H, ST_GAP_H, ST_VERIFY: mode_on_s = 1'b1;
      ST_ADV_M: begin
        mode_on_s = 1'b1;
        ma_nxt_s  = 1'b1;
      end
      ST_ADV_H: begin
        mode_on_s = 1'b1;
        ha_nxt_s  = 1'b1;
      end
`ifdef TSEQ_DAY_SET_EN
      ST_LOAD_D, ST_GAP_D: mode_on_s = 1'b1;
      ST_ADV_D: begin
        mode_on_s = 1'b1;
        da_nxt_s  = 1'b1;
      end
`endif
      default: mode_on_s = 1'b0;
    endcase
    ts_nxt_s   = mode_on_s && !mode_r;
    as_nxt_s   = mode_on_s && mode_r;
    busy_nxt_s = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Timeset  <= 1'b0;
      Alarmset <= 1'b0;
      Minadv   <= 1'b0;
      Hrsadv   <= 1'b0;
      Dayadv   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      Timeset  <= ts_nxt_s;
      Alarmset <= as_nxt_s;
      Minadv   <= ma_nxt_s;
      Hrsadv   <= ha_nxt_s;
      Dayadv   <= da_nxt_s;
      busy     <= busy_nxt_s;
      done     <= done_nxt_s;
      err      <= err_nxt_s;
    end
  end

endmodule

// File: doc/time_set_seq.md
Name: time_set_seq

Overview:
- Automated programming front-end for the clock/alarm top level.
- Given a target time, it drives the Timeset/Alarmset/Minadv/Hrsadv/Dayadv button lines that the clock datapath consumes, then checks the clock's count feedback until it matches.
- Runs on the same Pulse clock as the counters and replaces manual button pressing in system tests and board bring-up.

Parameters:
- MAX_RETRY, 2: extra correction passes allowed after a failed verify.
- SETTLE, 1: cycles the mode line is held before the first advance (range 1..15).

Ports:
- clk  in  1  Pulse clock shared with the counters
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle request; sampled only in IDLE
- alarm_mode  in  1  0 = program time (Timeset), 1 = program alarm (Alarmset); captured at start
- tgt_min  in  7  target minutes, legal range 0..59
- tgt_hrs  in  7  target hours, legal range 0..23
- tgt_day  in  7  target day, legal range 0..6; ignored when alarm_mode=1
- cur_min  in  7  displayed minutes feedback (the top-level Min mux output)
- cur_hrs  in  7  displayed hours feedback (Hrs mux output)
- cur_day  in  7  day counter feedback
- Timeset  out  1  to clock
- Alarmset  out  1  to clock
- Minadv  out  1  to clock
- Hrsadv  out  1  to clock
- Dayadv  out  1  to clock
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  1-cycle pulse at the end of the sequence
- err  out  1  level; cleared by the next accepted start

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, retry count 0, targets cleared.
- All outputs are registered.
- States: IDLE, CHECK, ENTER, LOAD_M, ADV_M, GAP_M, LOAD_H, ADV_H, GAP_H, LOAD_D, ADV_D, GAP_D, VERIFY, EXIT, DONE.
- IDLE:
  - start=1 captures targets and mode, then goes to CHECK.
  - start while not IDLE is ignored.
- CHECK:
  - Any target out of range: err=1, go to DONE. The mode line is never asserted.
  - Otherwise go to ENTER.
- ENTER:
  - Asserts Timeset (mode 0) or Alarmset (mode 1) for SETTLE cycles, then LOAD_M.
  - The mode line stays high through VERIFY and drops in EXIT.
  - Timeset and Alarmset are never high together.
- LOAD_x:
  - delta = (tgt + MOD - cur) mod MOD, with MOD = 60 / 24 / 7. Computed in 8-bit arithmetic.
  - delta=0 skips to the next LOAD (or VERIFY); otherwise the delta is loaded into the down-counter and the FSM goes to ADV_x.
- ADV_x:
  - The advance line is high for exactly delta consecutive cycles.
  - Only one advance line is high in any cycle.
- GAP_x:
  - One cycle with all advance lines low, so the feedback reflects the last advance.
  - Then the next phase: M→H→D→VERIFY.
  - D is skipped when alarm_mode=1.
- VERIFY:
  - Compares cur_* with the targets (day excluded in alarm mode).
  - Match: go to EXIT.
  - Mismatch with retries used < MAX_RETRY: increment and go to LOAD_M. This absorbs minute carries caused by Szero while the seconds counter is stopped at 0.
  - Mismatch with retries exhausted: err=1, go to EXIT.
- EXIT: mode line low for one cycle, then DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Wrap-around: cur=59, tgt=0 gives delta=1; cur=0, tgt=59 gives delta=59.
- Reset mid-sequence: all lines drop asynchronously; no done pulse.

Optional Feature:
- Macro: TSEQ_DAY_SET_EN.
- Defined: the D phase exists as described above.
- Undefined:
  - LOAD_D/ADV_D/GAP_D are not built.
  - Dayadv is tied to 0.
  - tgt_day and cur_day are ignored, including in CHECK and VERIFY.

Test Plan:
- Time mode, cur=10:05 day 2, tgt=12:07 day 4 (SETTLE=1)
  - Timeset high from cycle 2.
  - Minadv high 2 cycles, Hrsadv 2 cycles, Dayadv 2 cycles.
  - done pulse with err=0.
  - Total 17 cycles start→done.
- Wrap: cur min 59, tgt min 0 → exactly 1 Minadv cycle. cur hrs 0, tgt 23 → 23 Hrsadv cycles.
- Alarm mode, tgt 06:30 from 00:00:
  - Alarmset high and Timeset low throughout.
  - 30 Minadv cycles, 6 Hrsadv cycles, Dayadv never high.
- Out of range: tgt_min=60 → no button line ever high; err=1 with the done pulse 2 cycles after start.
- Feedback model that adds one extra minute on the first pass → VERIFY mismatch, one retry with 59 Minadv cycles, then done with err=0. With MAX_RETRY=0, err=1.
- rst_n low during ADV_H → all outputs 0 in the same cycle; a later start runs a full sequence normally.
